mt_axi_resp_latency_shim: RTL and testbench

//  Response-path latency injector for the fake AXI4 memory: sits between the axi_slave_ram R/B outputs and
//  the noc_axi4_bridge m_axi R/B inputs. Each R beat and B response is held for a fixed number of cycles

---
 rtl/mt_fake_axi_pkg.sv | 30 +++
 rtl/mt_axi_resp_delay_fifo.sv | 71 +++++++
 rtl/mt_axi_resp_latency_shim.sv | 58 +++++
 tb/tb_mt_axi_resp_latency_shim.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mt_fake_axi_pkg.sv
// Shared AXI response payload types and widths for the fake AXI4 memory path.
package mt_fake_axi_pkg;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned USER_W = 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
    logic [USER_W-1:0] user;
  } r_beat_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [1:0]        resp;
    logic [USER_W-1:0] user;
  } b_beat_t;

  localparam int unsigned R_PAYLOAD_W = $bits(r_beat_t);
  localparam int unsigned B_PAYLOAD_W = $bits(b_beat_t);

  // Down-counter width able to hold lat; a zero latency still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mt_axi_resp_delay_fifo.sv
// One response channel: circular FIFO whose entries ripen after LAT cycles
// before being offered downstream in strict arrival order.
module mt_axi_resp_delay_fifo
  import mt_fake_axi_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned LAT   = 20,
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_payload,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_payload
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = cnt_width(LAT);

  logic [W-1:0]     mem_q [DEPTH];
  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             full, empty, push, pop;

  assign wr_idx = wr_ptr_q[IDX_W-1:0];
  assign rd_idx = rd_ptr_q[IDX_W-1:0];
  assign full   = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) && (wr_idx == rd_idx);
  assign empty  = (wr_ptr_q == rd_ptr_q);

  // Everything downstream is a function of registered state only.
  assign s_ready   = !rst && !full;
  assign m_valid   = !rst && !empty && (cnt_q[rd_idx] == '0);
  assign m_payload = m_valid ? mem_q[rd_idx] : '0;

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // Counters keep ticking during downstream stalls and saturate at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) cnt_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (push && (wr_idx == IDX_W'(i))) cnt_q[i] <= CNT_W'(LAT);
        else if (cnt_q[i] != '0)           cnt_q[i] <= cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx] <= s_payload;
  end

endmodule

// File: rtl/mt_axi_resp_latency_shim.sv
// Response-path latency injector: independent delay FIFOs for the R and B
// channels between the fake AXI RAM and the NoC bridge.
module mt_axi_resp_latency_shim
  import mt_fake_axi_pkg::*;
#(
  parameter int unsigned RD_LATENCY  = 20,
  parameter int unsigned WR_LATENCY  = 20,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned R_PAYLOAD_W = mt_fake_axi_pkg::R_PAYLOAD_W,
  parameter int unsigned B_PAYLOAD_W = mt_fake_axi_pkg::B_PAYLOAD_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_r_valid,
  output logic                   s_r_ready,
  input  logic [R_PAYLOAD_W-1:0] s_r_payload,
  output logic                   m_r_valid,
  input  logic                   m_r_ready,
  output logic [R_PAYLOAD_W-1:0] m_r_payload,
  input  logic                   s_b_valid,
  output logic                   s_b_ready,
  input  logic [B_PAYLOAD_W-1:0] s_b_payload,
  output logic                   m_b_valid,
  input  logic                   m_b_ready,
  output logic [B_PAYLOAD_W-1:0] m_b_payload
);

  mt_axi_resp_delay_fifo #(
    .W     (R_PAYLOAD_W),
    .LAT   (RD_LATENCY),
    .DEPTH (DEPTH)
  ) u_r_fifo (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_r_valid),
    .s_ready   (s_r_ready),
    .s_payload (s_r_payload),
    .m_valid   (m_r_valid),
    .m_ready   (m_r_ready),
    .m_payload (m_r_payload)
  );

  mt_axi_resp_delay_fifo #(
    .W     (B_PAYLOAD_W),
    .LAT   (WR_LATENCY),
    .DEPTH (DEPTH)
  ) u_b_fifo (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_b_valid),
    .s_ready   (s_b_ready),
    .s_payload (s_b_payload),
    .m_valid   (m_b_valid),
    .m_ready   (m_b_ready),
    .m_payload (m_b_payload)
  );

endmodule

// File: tb/tb_mt_axi_resp_latency_shim.sv
// Directed bench for the response latency shim: one instance at 20/20 cycles,
// a second at RD=0 / WR=5.
module tb_mt_axi_resp_latency_shim;
  import mt_fake_axi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: RD_LATENCY=20, WR_LATENCY=20
  logic    rst_a;
  logic    sr_v_a, sr_r_a, mr_v_a, mr_r_a;
  logic    sb_v_a, sb_r_a, mb_v_a, mb_r_a;
  r_beat_t sr_p_a, mr_p_a;
  b_beat_t sb_p_a, mb_p_a;

  // Instance Z: RD_LATENCY=0, WR_LATENCY=5
  logic    rst_z;
  logic    sr_v_z, sr_r_z, mr_v_z, mr_r_z;
  logic    sb_v_z, sb_r_z, mb_v_z, mb_r_z;
  r_beat_t sr_p_z, mr_p_z;
  b_beat_t sb_p_z, mb_p_z;

  mt_axi_resp_latency_shim #(.RD_LATENCY(20), .WR_LATENCY(20), .DEPTH(16)) dut (
    .clk(clk), .rst(rst_a),
    .s_r_valid(sr_v_a), .s_r_ready(sr_r_a), .s_r_payload(sr_p_a),
    .m_r_valid(mr_v_a), .m_r_ready(mr_r_a), .m_r_payload(mr_p_a),
    .s_b_valid(sb_v_a), .s_b_ready(sb_r_a), .s_b_payload(sb_p_a),
    .m_b_valid(mb_v_a), .m_b_ready(mb_r_a), .m_b_payload(mb_p_a)
  );

  mt_axi_resp_latency_shim #(.RD_LATENCY(0), .WR_LATENCY(5), .DEPTH(16)) dut0 (
    .clk(clk), .rst(rst_z),
    .s_r_valid(sr_v_z), .s_r_ready(sr_r_z), .s_r_payload(sr_p_z),
    .m_r_valid(mr_v_z), .m_r_ready(mr_r_z), .m_r_payload(mr_p_z),
    .s_b_valid(sb_v_z), .s_b_ready(sb_r_z), .s_b_payload(sb_p_z),
    .m_b_valid(mb_v_z), .m_b_ready(mb_r_z), .m_b_payload(mb_p_z)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic r_beat_t rb(input int n, input logic last);
    r_beat_t b;
    logic [31:0] u;
    u      = 32'(n);
    b.id   = u[3:0];
    b.data = {u, ~u};
    b.resp = u[1:0];
    b.last = last;
    b.user = u[4];
    return b;
  endfunction

  function automatic b_beat_t bb(input int n);
    b_beat_t b;
    logic [31:0] u;
    u      = 32'(n);
    b.id   = u[3:0];
    b.resp = u[5:4];
    b.user = u[6];
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_a = 1'b1; rst_z = 1'b1;
    sr_v_a = 1'b0; mr_r_a = 1'b0; sb_v_a = 1'b0; mb_r_a = 1'b0;
    sr_v_z = 1'b0; mr_r_z = 1'b0; sb_v_z = 1'b0; mb_r_z = 1'b0;
    sr_p_a = '0; sb_p_a = '0; sr_p_z = '0; sb_p_z = '0;
    tickn(3);

    // Reset state
    chk("rst_s_r_ready", 128'(sr_r_a), 128'(0));
    chk("rst_s_b_ready", 128'(sb_r_a), 128'(0));
    chk("rst_m_r_valid", 128'(mr_v_a), 128'(0));
    chk("rst_m_b_valid", 128'(mb_v_a), 128'(0));
    chk("rst_m_r_payload", 128'(mr_p_a), 128'(0));
    chk("rst_m_b_payload", 128'(mb_p_a), 128'(0));
    rst_a = 1'b0; rst_z = 1'b0;
    tick();
    chk("post_rst_s_r_ready", 128'(sr_r_a), 128'(1));
    chk("post_rst_s_b_ready", 128'(sb_r_a), 128'(1));
    chk("post_rst_z_s_r_ready", 128'(sr_r_z), 128'(1));

    // Single R beat: visible exactly 20 cycles after acceptance
    mr_r_a = 1'b1;
    sr_v_a = 1'b1; sr_p_a = rb(1, 1'b1);
    tick();
    sr_v_a = 1'b0;
    tickn(19);
    chk("t1_not_ripe_at_19", 128'(mr_v_a), 128'(0));
    tick();
    chk("t1_valid_at_20", 128'(mr_v_a), 128'(1));
    chk("t1_payload", 128'(mr_p_a), 128'(rb(1, 1'b1)));
    tick();
    chk("t1_popped", 128'(mr_v_a), 128'(0));

    // 8-beat burst emerges back-to-back, rlast only on the last beat
    for (int i = 0; i < 8; i++) begin
      sr_v_a = 1'b1; sr_p_a = rb(100 + i, (i == 7));
      tick();
    end
    sr_v_a = 1'b0;
    tickn(12);
    chk("t2_not_ripe", 128'(mr_v_a), 128'(0));
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_valid_%0d", i), 128'(mr_v_a), 128'(1));
      chk($sformatf("t2_payload_%0d", i), 128'(mr_p_a), 128'(rb(100 + i, (i == 7))));
      tick();
    end
    chk("t2_drained", 128'(mr_v_a), 128'(0));

    // Fill to DEPTH with the sink stalled; 17th beat refused until a pop
    mr_r_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t3_ready_%0d", i), 128'(sr_r_a), 128'(1));
      sr_v_a = 1'b1; sr_p_a = rb(200 + i, 1'b0);
      tick();
    end
    chk("t3_full_ready_low", 128'(sr_r_a), 128'(0));
    sr_p_a = rb(216, 1'b1);
    tickn(25);
    chk("t3_still_full", 128'(sr_r_a), 128'(0));
    chk("t3_head_valid", 128'(mr_v_a), 128'(1));
    chk("t3_head_payload", 128'(mr_p_a), 128'(rb(200, 1'b0)));
    mr_r_a = 1'b1;
    tick();
    mr_r_a = 1'b0;
    chk("t3_ready_after_pop", 128'(sr_r_a), 128'(1));
    tick();
    sr_v_a = 1'b0;
    chk("t3_full_again", 128'(sr_r_a), 128'(0));

    // Long head stall: payload stable, then release drains one per cycle
    for (int i = 0; i < 500; i++) begin
      if (mr_v_a !== 1'b1 || mr_p_a !== rb(201, 1'b0))
        chk($sformatf("t4_stall_%0d", i), 128'({mr_v_a, mr_p_a}), 128'({1'b1, rb(201, 1'b0)}));
      tick();
    end
    chk("t4_stall_payload", 128'(mr_p_a), 128'(rb(201, 1'b0)));
    mr_r_a = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t4_drain_valid_%0d", k), 128'(mr_v_a), 128'(1));
      chk($sformatf("t4_drain_payload_%0d", k), 128'(mr_p_a), 128'(rb(201 + k, (k == 15))));
      tick();
    end
    chk("t4_empty", 128'(mr_v_a), 128'(0));
    chk("t4_ready", 128'(sr_r_a), 128'(1));

    // RD=0 / WR=5 instance: R next cycle, B five cycles later, interleaved
    mr_r_z = 1'b1; mb_r_z = 1'b1;
    sr_v_z = 1'b1; sr_p_z = rb(300, 1'b1);
    sb_v_z = 1'b1; sb_p_z = bb(77);
    tick();
    sb_v_z = 1'b0;
    sr_p_z = rb(301, 1'b0);
    chk("t5_r0_valid", 128'(mr_v_z), 128'(1));
    chk("t5_r0_payload", 128'(mr_p_z), 128'(rb(300, 1'b1)));
    chk("t5_b_not_yet_1", 128'(mb_v_z), 128'(0));
    tick();
    sr_v_z = 1'b0;
    chk("t5_r1_valid", 128'(mr_v_z), 128'(1));
    chk("t5_r1_payload", 128'(mr_p_z), 128'(rb(301, 1'b0)));
    chk("t5_b_not_yet_2", 128'(mb_v_z), 128'(0));
    tick();
    chk("t5_r_drained", 128'(mr_v_z), 128'(0));
    tickn(1);
    tick();
    chk("t5_b_not_yet_4", 128'(mb_v_z), 128'(0));
    tick();
    chk("t5_b_valid_5", 128'(mb_v_z), 128'(1));
    chk("t5_b_payload", 128'(mb_p_z), 128'(bb(77)));
    tick();
    chk("t5_b_popped", 128'(mb_v_z), 128'(0));

    // Reset with beats queued on both channels drops everything
    mr_r_a = 1'b0; mb_r_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sr_v_a = 1'b1; sr_p_a = rb(400 + i, (i == 4));
      sb_v_a = (i < 2); sb_p_a = bb(40 + i);
      tick();
    end
    sr_v_a = 1'b0; sb_v_a = 1'b0;
    tickn(25);
    chk("t6_r_ripe", 128'(mr_v_a), 128'(1));
    chk("t6_b_ripe", 128'(mb_v_a), 128'(1));
    chk("t6_b_payload", 128'(mb_p_a), 128'(bb(40)));
    rst_a = 1'b1;
    tick();
    chk("t6_rst_m_r_valid", 128'(mr_v_a), 128'(0));
    chk("t6_rst_m_b_valid", 128'(mb_v_a), 128'(0));
    chk("t6_rst_s_r_ready", 128'(sr_r_a), 128'(0));
    chk("t6_rst_m_r_payload", 128'(mr_p_a), 128'(0));
    rst_a = 1'b0;
    tick();
    chk("t6_rel_s_r_ready", 128'(sr_r_a), 128'(1));
    chk("t6_rel_s_b_ready", 128'(sb_r_a), 128'(1));
    chk("t6_rel_m_r_valid", 128'(mr_v_a), 128'(0));
    mr_r_a = 1'b1; mb_r_a = 1'b1;
    tickn(30);
    chk("t6_empty_r", 128'(mr_v_a), 128'(0));
    chk("t6_empty_b", 128'(mb_v_a), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
